// File: rtl/adder_result_accum.sv
// Accumulates a batch of {cout, s} adder results and presents the total, sample count and a
// sticky wrap flag on a valid/ready port, stalling the producer while the result is pending.
module adder_result_accum #(
   parameter int unsigned N     = 32,
   parameter int unsigned BATCH = 8,
   parameter int unsigned ACC_W = 40,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [N-1:0]     s_i,
   input  logic             cout_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [ACC_W-1:0] out_sum_o,
   output logic [CNT_W-1:0] out_count_o,
   output logic             out_ovf_o
);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BATCH - 1);

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;

   logic               accept;
   logic [ACC_W-1:0]   sample;
   logic [ACC_W:0]     add_full;

   assign sample   = ACC_W'({cout_i, s_i});
   assign add_full = {1'b0, acc_q} + {1'b0, sample};
   assign accept   = in_valid_i && (state_q != StDone);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (accept) begin
         acc_d = add_full[ACC_W-1:0];
         cnt_d = cnt_q + 1'b1;
         ovf_d = ovf_q | add_full[ACC_W];
      end
      unique case (state_q)
         StIdle: begin
            // A lone flush in IDLE would close an empty batch, so it needs a sample too.
            if (accept) begin
               state_d = (BATCH == 1 || flush_i) ? StDone : StAccum;
            end
         end
         StAccum: begin
            if ((accept && cnt_q == LastCnt) || flush_i) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready_o  = (state_q != StDone);
   assign out_valid_o = (state_q == StDone);
   assign out_sum_o   = acc_q;
   assign out_count_o = cnt_q;
   assign out_ovf_o   = ovf_q;

endmodule

// File: tb/tb_adder_result_accum.sv
// Directed bench: a 40-bit and a 34-bit accumulator share one stimulus stream (BATCH = 4).
module tb_adder_result_accum;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] s;
   logic        cout;
   logic        flush;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_ovf;
   logic [39:0] a_sum;
   logic [7:0]  a_cnt;
   logic        b_in_ready, b_out_valid, b_ovf;
   logic [33:0] b_sum;
   logic [7:0]  b_cnt;

   int n_pass;
   int n_total;

   adder_result_accum #(.N(32), .BATCH(4), .ACC_W(40), .CNT_W(8)) dut_a (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (a_in_ready),
      .s_i         (s),
      .cout_i      (cout),
      .flush_i     (flush),
      .out_valid_o (a_out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (a_sum),
      .out_count_o (a_cnt),
      .out_ovf_o   (a_ovf)
   );

   adder_result_accum #(.N(32), .BATCH(4), .ACC_W(34), .CNT_W(8)) dut_b (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (b_in_ready),
      .s_i         (s),
      .cout_i      (cout),
      .flush_i     (flush),
      .out_valid_o (b_out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (b_sum),
      .out_count_o (b_cnt),
      .out_ovf_o   (b_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [39:0] sum,
                        input logic [7:0] cnt, input logic ovf);
      chk({tag, ".valid"}, 64'(a_out_valid), 64'(v));
      chk({tag, ".ready"}, 64'(a_in_ready), 64'(!v));
      chk({tag, ".sum"}, 64'(a_sum), 64'(sum));
      chk({tag, ".count"}, 64'(a_cnt), 64'(cnt));
      chk({tag, ".ovf"}, 64'(a_ovf), 64'(ovf));
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      s         = '0;
      cout      = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;

      // Reset state
      #1;
      chk_a("reset", 1'b0, 40'd0, 8'd0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      chk_a("post_reset", 1'b0, 40'd0, 8'd0, 1'b0);

      // Basic batch 1+2+3+4
      in_valid = 1'b1;
      s = 32'd1; step();
      s = 32'd2; step();
      s = 32'd3; step();
      s = 32'd4; step();
      chk_a("basic", 1'b1, 40'd10, 8'd4, 1'b0);
      // Offered during DONE: must be ignored
      s = 32'hFFFF_FFFF; cout = 1'b1;
      step();
      chk_a("basic_clear", 1'b0, 40'd0, 8'd0, 1'b0);

      // Carry path: 4 x 0x1_FFFFFFFF
      step(); step(); step();
      chk_a("carry_partial", 1'b0, 40'h5_FFFF_FFFD, 8'd3, 1'b0);
      step();
      chk_a("carry", 1'b1, 40'h7_FFFF_FFFC, 8'd4, 1'b0);
      chk("wrap34.sum", 64'(b_sum), 64'h3_FFFF_FFFC);
      chk("wrap34.ovf", 64'(b_ovf), 64'd1);
      chk("wrap34.valid", 64'(b_out_valid), 64'd1);
      in_valid = 1'b0;
      step();
      chk("wrap34_clear.ovf", 64'(b_ovf), 64'd0);

      // Sticky flag cleared for the next batch
      in_valid = 1'b1; s = 32'd1; cout = 1'b0;
      step(); step(); step(); step();
      chk("next34.sum", 64'(b_sum), 64'd4);
      chk("next34.ovf", 64'(b_ovf), 64'd0);
      chk("next34.count", 64'(b_cnt), 64'd4);
      chk_a("next40", 1'b1, 40'd4, 8'd4, 1'b0);
      in_valid = 1'b0;
      step();

      // Flush with a sample in the same cycle
      in_valid = 1'b1; s = 32'd5;
      step();
      chk_a("flush_first", 1'b0, 40'd5, 8'd1, 1'b0);
      s = 32'd7; flush = 1'b1;
      step();
      chk_a("flush", 1'b1, 40'd12, 8'd2, 1'b0);
      in_valid = 1'b0; flush = 1'b0;
      step();
      chk_a("flush_clear", 1'b0, 40'd0, 8'd0, 1'b0);

      // Flush pulse in IDLE with no sample
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk_a("idle_flush", 1'b0, 40'd0, 8'd0, 1'b0);
      step();
      chk_a("idle_flush2", 1'b0, 40'd0, 8'd0, 1'b0);

      // Back-pressure
      out_ready = 1'b0; in_valid = 1'b1;
      s = 32'd10; step();
      s = 32'd20; step();
      s = 32'd30; step();
      s = 32'd40; step();
      s = 32'd99;
      for (int i = 0; i < 10; i++) begin
         chk_a($sformatf("stall%0d", i), 1'b1, 40'd100, 8'd4, 1'b0);
         step();
      end
      chk_a("stall_end", 1'b1, 40'd100, 8'd4, 1'b0);
      out_ready = 1'b1;
      step();
      chk_a("bp_handshake", 1'b0, 40'd0, 8'd0, 1'b0);
      step();
      chk_a("bp_pending", 1'b0, 40'd99, 8'd1, 1'b0);

      // Reset mid-batch after two samples
      s = 32'd1;
      step();
      chk_a("pre_reset", 1'b0, 40'd100, 8'd2, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_a("mid_reset", 1'b0, 40'd0, 8'd0, 1'b0);
      #1 rst_n = 1'b1;
      step();
      in_valid = 1'b1; s = 32'd1;
      step(); step(); step(); step();
      chk_a("after_reset", 1'b1, 40'd4, 8'd4, 1'b0);
      in_valid = 1'b0;
      step();
      chk_a("after_reset_clear", 1'b0, 40'd0, 8'd0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/adder_result_accum.md
# adder_result_accum

Downstream consumer of the `fa32bit` adder. Each accepted sample is the adder's `{cout, s}` result, and the block sums a batch of them into a wide accumulator. When the batch completes, it presents the total, the sample count and a sticky overflow flag on a valid/ready output port. The block sits between the adder datapath and the result sink, and applies back-pressure to the adder-side producer while the result is waiting to be taken.

## Interface
- `N`, 32, adder operand/sum width
- `BATCH`, 8, samples per full batch (1 ≤ BATCH ≤ 2^CNT_W − 1)
- `ACC_W`, 40, accumulator width (≥ N+1)
- `CNT_W`, 8, sample-counter width

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  producer presents a sample
- `in_ready`  out  1  block can accept a sample
- `s`  in  N  adder sum
- `cout`  in  1  adder carry-out
- `flush`  in  1  close the current batch early
- `out_valid`  out  1  batch result available
- `out_ready`  in  1  sink takes the result
- `out_sum`  out  ACC_W  batch total, modulo 2^ACC_W
- `out_count`  out  CNT_W  samples in the batch
- `out_ovf`  out  1  sticky: the accumulator wrapped during the batch

## Operation
- Sample value is `{cout, s}` zero-extended to ACC_W bits, so the range is 0 … 2^(N+1)−1.
- A sample is accepted when `in_valid && in_ready` on a rising edge. On accept:
  - acc ← acc + sample, mod 2^ACC_W.
  - count ← count + 1.
  - ovf ← ovf | carry-out of the ACC_W-bit add.
- FSM states:
  - IDLE (count = 0)
  - ACCUM (0 < count < BATCH)
  - DONE
- Transitions:
  - IDLE, accept: → ACCUM, or → DONE if BATCH = 1.
  - ACCUM, accept with count = BATCH−1: → DONE.
  - ACCUM, `flush`: → DONE. A sample accepted in the same cycle as `flush` is included in the batch.
  - IDLE, `flush` with no accept: ignored, stays IDLE.
  - IDLE, `flush` with accept: → DONE with count = 1.
  - DONE, `out_ready`: → IDLE; acc, count and ovf clear to 0.
- `in_ready` = (state ≠ DONE), decoded combinationally from the state register only. It does not depend on `in_valid` or `out_ready`.
- `out_valid` = (state = DONE).
- `out_sum`, `out_count` and `out_ovf` are driven directly from the acc, count and ovf registers. They are stable for as long as `out_valid` is high.
- `flush` and `in_valid` are ignored in DONE.
- `s` and `cout` are don't-care when no accept occurs.

## Timing
- Reset (`rst_n` low, asynchronous): state = IDLE and acc, count, ovf = 0. As a result:
  - `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `out_ovf` = 0.
  - `in_ready` = 1, but no accept can occur while `rst_n` is low.
- Reset deassertion takes effect at the next rising edge.
- Latency: `out_valid` rises on the edge that accepts the last sample, or on the edge that samples `flush`. That is 1 cycle after the final accept is presented.
- Output handshake completes on the edge where `out_valid && out_ready`.
  - `in_ready` returns to 1 after that edge.
  - The earliest next accept is therefore one cycle after the handshake.
- Full-batch throughput: BATCH + 1 cycles when the producer and sink never stall.
- `out_valid` never drops without a handshake, except on reset.
- Reset mid-batch or while in DONE discards the partial or pending result, with no output handshake.
- Wrap-around: out_sum holds the low ACC_W bits and out_ovf stays 1 until the clear in DONE.

## Test plan
- N=32, BATCH=4, ACC_W=40: accept s = 1, 2, 3, 4 with cout = 0 on back-to-back cycles, `out_ready` = 1 → `out_valid` for exactly 1 cycle with `out_sum` = 10, `out_count` = 4, `out_ovf` = 0; the next batch is accepted 1 cycle later.
- Carry path: 4 × (s = 0xFFFFFFFF, cout = 1) → `out_sum` = 0x7_FFFFFFFC, `out_ovf` = 0.
- Overflow, ACC_W = 34: the same 4 samples → `out_sum` = 0x3_FFFFFFFC, `out_ovf` = 1. The next batch of s = 1 × 4 → `out_sum` = 4, `out_ovf` = 0 (sticky flag cleared).
- Flush: accept s = 5, then s = 7 with `flush` = 1 in the same cycle → `out_sum` = 12, `out_count` = 2. A `flush` pulse in IDLE with no `in_valid` → `out_valid` stays 0.
- Back-pressure: complete a batch, hold `out_ready` = 0 for 10 cycles with `in_valid` = 1 → `in_ready` = 0 throughout, outputs unchanged, no sample lost. The pending sample is accepted 1 cycle after `out_ready` = 1.
- Reset: after 2 of 4 samples, pulse `rst_n` low mid-cycle → all outputs 0 immediately. A following full batch s = 1 × 4 → `out_sum` = 4, `out_count` = 4.
